perf_stat_unit: RTL
===================

Name: perf_stat_unit

Overview:
- Synthesizable event-counter bank that brings the pipelined CPU's cycle, retire and cache hit/request statistics into hardware.
- Sits beside `cpu` and samples one-bit event strobes every cycle: retire, I/D-cache req/hit, stall, flush.
- Freezes on halt or watchdog timeout, then streams every counter out over a valid/ready dump port.
- Any counter can also be read live through a registered read port.

Parameters:
- NUM_CH, 4: number of generic event channels (evt inputs).
- CNT_W, 32: width of every counter.
- TIMEOUT, 100000: watchdog cycle limit; must be < 2**CNT_W; 0 disables the watchdog.
- SEL_W, $clog2(NUM_CH+2): slot index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin counting.
- clear  in  1  synchronous clear of all counters and flags; returns to IDLE.
- hlt  in  1  CPU halt strobe.
- retire  in  1  instruction retired this cycle (RegWrite | MemWrite | hlt).
- evt  in  NUM_CH  per-channel event strobes.
- rd_sel  in  SEL_W  live-read slot index.
- rd_data  out  CNT_W  registered value of slot rd_sel.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts the dump word.
- dump_idx  out  SEL_W  slot index of the current dump word.
- dump_data  out  CNT_W  counter value of the current dump word.
- ovf  out  NUM_CH+2  sticky per-slot overflow flags.
- timeout  out  1  sticky: watchdog expired.
- running  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Slot map:
  - slot 0 = cycle count.
  - slot 1 = retire count.
  - slot 2+i = evt[i].
  - NUM_SLOTS = NUM_CH+2.
- Reset (async, rst=1): state IDLE; all counters, ovf, timeout, rd_data, dump_data and dump_idx are 0; dump_valid and done are 0. Asserting rst mid-run or mid-dump aborts immediately.
- clear has priority over every other input in every state. The cycle after clear, the outputs match their reset values.
- IDLE: counters hold. Go to RUN on start.
- RUN, every cycle:
  - Cycle counter increments.
  - Retire counter increments when retire=1.
  - evt[i] counter increments when evt[i]=1.
  - A cycle in which hlt=1 is counted, then RUN goes to DUMP.
  - If TIMEOUT != 0 and the cycle counter's next value equals TIMEOUT, set timeout, count that cycle, then go to DUMP. If hlt and timeout coincide, set timeout and go to DUMP once.
- DUMP:
  - Counters frozen; start, hlt and evt are ignored.
  - dump_valid=1, dump_idx starts at 0, dump_data = slot[dump_idx].
  - On dump_valid & dump_ready, dump_idx increments next cycle. Data and index stay stable while ready=0.
  - A handshake on index NUM_SLOTS-1 moves to DONE; dump_valid deasserts next cycle.
- DONE: counters frozen, done=1. Only clear or rst leaves this state; start is ignored.
- Counter arithmetic:
  - Unsigned CNT_W bits; wraps modulo 2**CNT_W.
  - Increment from all-ones sets the slot's ovf bit, which stays sticky until clear or rst.
- Live read: rd_data <= slot[rd_sel] each cycle, 1-cycle latency, valid in every state. If rd_sel >= NUM_SLOTS, rd_data = 0.
- Bypass: a live read in the same cycle as an increment returns the pre-increment value.

Optional Feature:
- Macro PERF_SATURATE_EN.
- Defined: counters saturate at all-ones; the increment that would wrap sets ovf and the counter holds at 2**CNT_W-1.
- Undefined: counters wrap as described in Behaviour; ovf is still set.
- The watchdog compare is unaffected either way.

Decomposition:
- Package perf_pkg holds:
  - state enum (IDLE, RUN, DUMP, DONE);
  - slot constants SLOT_CYCLE=0, SLOT_RETIRE=1, SLOT_EVT0=2.
- Sub-module perf_ctr: one CNT_W counter with inputs inc and clr and a sticky ovf output. The saturate/wrap choice lives here. Instantiated NUM_SLOTS times via generate.

Test Plan (NUM_CH=4, CNT_W=16, TIMEOUT=50 unless stated):
1. rst held 2 cycles; start; run 10 cycles; assert rst → all outputs 0 and running=0 the same cycle; no further counting after release.
2. start; retire=1 every cycle, evt[0] every other cycle, evt[3]=1 constantly; hlt on the 20th RUN cycle → dump words (0,20) (1,20) (2,10) (3,0) (4,0) (5,20); done=1 after the 6th handshake.
3. During case 2, hold dump_ready=0 for 3 cycles at idx 2 → dump_idx=2 and dump_data=10 stay stable; no word is skipped or repeated.
4. No hlt, evt idle → timeout=1 after 50 RUN cycles; dump slot 0 = 50, slot 1 = 0.
5. CNT_W=8, TIMEOUT=0, evt[1]=1 for 260 cycles then hlt → slot 3 = 4 and ovf[3]=1; with PERF_SATURATE_EN slot 3 = 255 and ovf[3]=1; slot 0 behaves likewise.
6. clear asserted mid-DUMP at idx 3 → next cycle state IDLE, dump_valid=0, rd_data of every slot = 0 (one-cycle latency), ovf=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared state encoding and slot map for the performance statistics unit.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } perf_state_t;

  localparam int SLOT_CYCLE  = 0;
  localparam int SLOT_RETIRE = 1;
  localparam int SLOT_EVT0   = 2;

endpackage

// File: rtl/perf_ctr.sv
// One statistics counter with a sticky overflow flag.
// Optional macro PERF_SATURATE_EN: hold at all-ones instead of wrapping.
module perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
        cnt <= cnt;
`else
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_stat_unit.sv
// Event-counter bank: counts CPU events in RUN, freezes on halt/watchdog, streams all slots out.
// Optional macro PERF_SATURATE_EN (handled in perf_ctr): counters saturate instead of wrapping.
module perf_stat_unit
  import perf_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000,
  parameter int SEL_W   = $clog2(NUM_CH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  hlt,
  input  logic                  retire,
  input  logic [NUM_CH-1:0]     evt,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [SEL_W-1:0]      dump_idx,
  output logic [CNT_W-1:0]      dump_data,
  output logic [NUM_CH+1:0]     ovf,
  output logic                  timeout,
  output logic                  running,
  output logic                  done
);

  localparam int               NUM_SLOTS = NUM_CH + 2;
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

  perf_state_t          state, state_n;
  logic [CNT_W-1:0]     cnt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] inc;
  logic [CNT_W-1:0]     rd_mux;
  logic                 to_hit;
  logic                 dump_fire;

  assign running    = (state == RUN);
  assign done       = (state == DONE);
  assign dump_valid = (state == DUMP);

  // Dump handshake: a word transfers on a cycle with dump_valid && dump_ready;
  // while dump_ready is low, dump_idx and dump_data hold their values.
  assign dump_fire = dump_valid & dump_ready;

  // Watchdog looks at the cycle counter's next value so the expiring cycle is still counted.
  assign to_hit = (TIMEOUT != 0) && ((cnt[SLOT_CYCLE] + CNT_W'(1)) == TO_VAL);

  always_comb begin
    inc = '0;
    if (state == RUN) begin
      inc[SLOT_CYCLE]               = 1'b1;
      inc[SLOT_RETIRE]              = retire;
      inc[SLOT_EVT0 +: NUM_CH]      = evt;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_ctr
    perf_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (inc[g]),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end

  always_comb begin
    rd_mux    = '0;
    dump_data = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (rd_sel == SEL_W'(k))   rd_mux    = cnt[k];
      if (dump_idx == SEL_W'(k)) dump_data = cnt[k];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (hlt || to_hit) state_n = DUMP;
      DUMP:    if (dump_fire && dump_idx == LAST_IDX) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timeout  <= 1'b0;
      dump_idx <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        timeout  <= 1'b0;
        dump_idx <= '0;
        rd_data  <= '0;
      end else begin
        if (state == RUN && to_hit) timeout <= 1'b1;
        if (dump_fire && dump_idx != LAST_IDX) dump_idx <= dump_idx + SEL_W'(1);
        rd_data <= rd_mux;
      end
    end
  end

endmodule
